// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC generator plus DEPTH-entry prefetch queue feeding ID.
// Ports: clk_i/rst_i, start_i, flush_i/redirect_pc_i, imem req/gnt/rvalid,
// inst/pc/valid/ready to ID. IF_PERF_CNT_EN adds perf_fetch_o/perf_drop_o.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            inst_ready_i
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_drop_o
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   outst_nxt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] inst_q [DEPTH];

  logic [CW:0]     inflight;
  logic            accept;
  logic            enq;
  logic            drop;
  logic            pop;
  logic [XLEN-1:0] redirect;

  // Credit covers both queued entries and fetches still in flight, so
  // every granted request is guaranteed a queue slot on return.
  assign inflight = {1'b0, occ} + {1'b0, outst};
  assign imem_req_o = rst_i & start_i & ~flush_i & (inflight < LIMIT);
  assign imem_addr_o = fetch_pc;
  assign accept = imem_req_o & imem_gnt_i;

  // Responses issued before a redirect are dropped until discard drains.
  assign enq  = imem_rvalid_i & ~flush_i & (discard == '0);
  assign drop = imem_rvalid_i & ~enq;

  assign inst_valid_o = (occ != '0);
  assign pop = inst_valid_o & inst_ready_i & ~flush_i;
  assign inst_o = inst_valid_o ? inst_q[rd_ptr] : '0;
  assign pc_o   = inst_valid_o ? pc_q[rd_ptr]   : '0;

  assign redirect = redirect_pc_i & ~XLEN'(3);
  assign outst_nxt = outst + CW'(accept) - CW'(imem_rvalid_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      occ      <= '0;
      outst    <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (flush_i) begin
      fetch_pc <= redirect;
      resp_pc  <= redirect;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      outst    <= outst_nxt;
      discard  <= outst_nxt;
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      if (enq) begin
        resp_pc <= resp_pc + XLEN'(4);
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ   <= occ + CW'(enq) - CW'(pop);
      outst <= outst_nxt;
      if (drop) discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (enq) begin
      pc_q[wr_ptr]   <= resp_pc;
      inst_q[wr_ptr] <= imem_rdata_i;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_fetch_o <= '0;
      perf_drop_o  <= '0;
    end else begin
      if (enq && perf_fetch_o != '1) perf_fetch_o <= perf_fetch_o + 32'd1;
      if (drop && perf_drop_o != '1) perf_drop_o <= perf_drop_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench with a transaction-level fetch model.
// Memory model returns f(addr) with per-scenario latency, in order.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i = 1'b0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_drop_o;
`endif

  always #5 clk = ~clk;

  if_fetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .flush_i(flush_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .pc_o(pc_o), .inst_ready_i(inst_ready_i)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_o(perf_fetch_o), .perf_drop_o(perf_drop_o)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic stale; logic [31:0] addr; } fl_t;

  mreq_t       mem_q[$];
  fl_t         infl[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = '0;
  int          exp_nfetch = 0;
  int          exp_ndrop = 0;
  logic [31:0] popped[$];
  logic [31:0] granted[$];
  int          first_gnt = -1;
  int          first_val = -1;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hCAFE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, got, want, $time);
    end
  endtask

  // One clock: memory drives response at negedge, outputs are compared
  // against the model, then the model advances across the posedge.
  task automatic step();
    logic e_req, e_valid, acc, rsp, popv;
    logic [31:0] gaddr;
    int ct;
    fl_t fl;
    @(negedge clk);
    rsp = rst_i && mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_rvalid_i = rsp;
    imem_rdata_i = rsp ? f(mem_q[0].addr) : 32'h0;
    #1;
    e_valid = exp_q.size() > 0;
    e_req = rst_i && start_i && !flush_i &&
            (exp_q.size() + infl.size() < DEPTH);
    chk("req", {31'b0, imem_req_o}, {31'b0, e_req});
    if (e_req) chk("addr", imem_addr_o, exp_fetch);
    chk("valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
    chk("pc", pc_o, e_valid ? exp_q[0] : 32'h0);
    chk("inst", inst_o, e_valid ? f(exp_q[0]) : 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_o, exp_nfetch);
    chk("perf_drop", perf_drop_o, exp_ndrop);
`endif
    acc = imem_req_o && imem_gnt_i;
    gaddr = imem_addr_o;
    popv = e_valid && inst_ready_i && !flush_i;
    ct = cyc;
    @(posedge clk);
    cyc++;
    if (!rst_i) begin
      mem_q.delete();
    end else begin
      if (rsp) void'(mem_q.pop_front());
      if (acc) begin
        mem_q.push_back('{addr: gaddr, due: ct + lat});
        granted.push_back(gaddr);
        if (first_gnt < 0) first_gnt = ct;
      end
      if (e_valid && first_val < 0) first_val = ct;
      if (popv) begin
        popped.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (rsp) begin
        if (infl.size() == 0) begin
          chk("spurious_rsp", 32'h1, 32'h0);
        end else begin
          fl = infl.pop_front();
          if (flush_i || fl.stale) begin
            exp_ndrop++;
          end else begin
            exp_q.push_back(fl.addr);
            exp_nfetch++;
          end
        end
      end
      if (flush_i) begin
        exp_q.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
        exp_fetch = redirect_pc_i & 32'hFFFF_FFFC;
      end else if (e_req && imem_gnt_i) begin
        infl.push_back('{stale: 1'b0, addr: exp_fetch});
        exp_fetch += 32'd4;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush_i = 1'b1;
    redirect_pc_i = pc;
    step();
    flush_i = 1'b0;
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_o, 32'h0);
    chk("rst_perf_drop", perf_drop_o, 32'h0);
`endif
    mem_q.delete();
    infl.delete();
    exp_q.delete();
    exp_fetch = '0;
    exp_nfetch = 0;
    exp_ndrop = 0;
    imem_rvalid_i = 1'b0;
  endtask

  logic [31:0] a0;
  int np;

  initial begin
    // Reset state
    #3;
    chk("por_req", {31'b0, imem_req_o}, 32'h0);
    chk("por_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("por_pc", pc_o, 32'h0);
    chk("por_inst", inst_o, 32'h0);
    chk("por_addr", imem_addr_o, 32'h0);
    run(2);

    // 1: zero-wait streaming
    rst_i = 1'b1;
    start_i = 1'b1;
    imem_gnt_i = 1'b1;
    inst_ready_i = 1'b1;
    lat = 1;
    run(8);
    chk("s1_g0", granted[0], 32'h0);
    chk("s1_g1", granted[1], 32'h4);
    chk("s1_g2", granted[2], 32'h8);
    chk("s1_lat", first_val - first_gnt, 32'd2);
    chk("s1_npop", popped.size(), 32'd6);
    chk("s1_p0", popped[0], 32'h0);
    chk("s1_p5", popped[5], 32'd20);

    // 2: ID stall fills queue, then drains
    inst_ready_i = 1'b0;
    do_flush(32'h0);
    granted.delete();
    run(8);
    chk("s2_req_off", {31'b0, imem_req_o}, 32'h0);
    chk("s2_valid", {31'b0, inst_valid_o}, 32'h1);
    chk("s2_head", pc_o, 32'h0);
    chk("s2_ngrant", granted.size(), 32'd4);
    inst_ready_i = 1'b1;
    popped.delete();
    granted.delete();
    run(6);
    chk("s2_p0", popped[0], 32'h0);
    chk("s2_p1", popped[1], 32'h4);
    chk("s2_p2", popped[2], 32'h8);
    chk("s2_p3", popped[3], 32'hC);
    chk("s2_p4", popped[4], 32'h10);
    chk("s2_resume", granted[0], 32'h10);

    // 4: unaligned redirect; flush against rvalid and pending pop
    do_flush(32'h102);
    chk("s4_req", {31'b0, imem_req_o}, 32'h1);
    chk("s4_addr", imem_addr_o, 32'h100);
    popped.delete();
    run(5);
    chk("s4_first", popped[0], 32'h100);
    chk("s4_pre_valid", {31'b0, inst_valid_o}, 32'h1);
    chk("s4_pre_rsp", mem_q.size(), 32'd1);
    np = popped.size();
    do_flush(32'h300);
    chk("s4_empty", {31'b0, inst_valid_o}, 32'h0);
    chk("s4_pc0", pc_o, 32'h0);
    run(4);
    chk("s4_after", popped[np], 32'h300);

    // 5: grant stall, then start_i drop with 3 outstanding
    imem_gnt_i = 1'b0;
    a0 = imem_addr_o;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s5_req_hold", {31'b0, imem_req_o}, 32'h1);
      chk("s5_addr_hold", imem_addr_o, a0);
    end
    imem_gnt_i = 1'b1;
    granted.delete();
    run(2);
    chk("s5_gnt0", granted[0], a0);
    chk("s5_gnt1", granted[1], a0 + 32'd4);
    lat = 4;
    do_flush(32'h400);
    granted.delete();
    popped.delete();
    run(3);
    start_i = 1'b0;
    run(10);
    chk("s5_ngrant", granted.size(), 32'd3);
    chk("s5_npop", popped.size(), 32'd3);
    chk("s5_p0", popped[0], 32'h400);
    chk("s5_p1", popped[1], 32'h404);
    chk("s5_p2", popped[2], 32'h408);

    // Mid-run asynchronous reset
    start_i = 1'b1;
    lat = 1;
    run(4);
    start_i = 1'b0;
    async_reset();
    run(2);
    #1;
    rst_i = 1'b1;

    // 3: flush drops two late responses (latency 3)
    lat = 3;
    start_i = 1'b1;
    run(2);
    do_flush(32'h100);
    popped.delete();
    run(12);
    start_i = 1'b0;
    run(6);
    chk("s3_first", popped[0], 32'h100);
    chk("s3_drained", {31'b0, inst_valid_o}, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("s3_perf_drop", perf_drop_o, 32'd2);
    chk("s3_perf_fetch", perf_fetch_o, popped.size());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end for the next-generation pipelined core; it replaces the single-register PC/IF path with a PC generator plus a DEPTH-entry prefetch queue. It drives a request/grant/response instruction-memory interface with variable latency and in-order responses. It presents {pc, inst} to ID through a valid/ready handshake and supports branch redirect with flush of queued and in-flight fetches.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries and max (occupancy + outstanding); power of 2, >=2
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  fetch enable; no new requests while low
flush_i  in  1  redirect strobe from branch resolution
redirect_pc_i  in  XLEN  new fetch PC, sampled when flush_i=1
imem_req_o  out  1  fetch request
imem_addr_o  out  XLEN  request address, word-aligned
imem_gnt_i  in  1  request accepted this cycle (req&gnt)
imem_rvalid_i  in  1  response valid, one per grant, in order, >=1 cycle after grant
imem_rdata_i  in  XLEN  response instruction
inst_valid_o  out  1  queue head valid
inst_o  out  XLEN  head instruction
pc_o  out  XLEN  head PC
inst_ready_i  in  1  ID accepts head (low = ID stall)

Behaviour:
- Reset (async, rst_i=0): fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, discard=0; imem_req_o=0, inst_valid_o=0, inst_o=0, pc_o=0. inst_o/pc_o read 0 whenever queue empty.
- Counters occupancy, outstanding, discard are $clog2(DEPTH+1) bits; invariant occupancy+outstanding<=DEPTH, so no overflow.
- Request: imem_req_o = start_i & ~flush_i & (occupancy+outstanding<DEPTH); imem_addr_o=fetch_pc. Accept when req&gnt: fetch_pc+=4 (wraps mod 2^XLEN), outstanding+1. With req high and gnt low, addr held stable; req drops only on flush or loss of credit.
- Response (rvalid): outstanding-1. If discard>0: drop, discard-1. Else enqueue {resp_pc, rdata}, resp_pc+=4. Entry visible on inst_valid_o the next cycle (rvalid->valid latency 1). Zero-wait memory: req/gnt at t, rvalid t+1, inst_valid_o t+2.
- Pop: inst_valid_o & inst_ready_i & ~flush_i; head advances next cycle. Enqueue and pop in the same cycle are both performed; occupancy is unchanged.
- Grant and response in the same cycle: outstanding unchanged.
- Flush (flush_i=1 at cycle t): no request at t; pop ignored; any response at t dropped. At t+1: queue empty, fetch_pc=resp_pc={redirect_pc_i[XLEN-1:2],2'b00}, discard=outstanding after counting the t response, so every pre-flush in-flight response is dropped. Back-to-back flushes: the latest redirect wins; discard accumulates correctly.
- start_i low: requests stop; outstanding responses complete and enqueue normally; queue still drains.
- Memory must share rst_i; no responses for pre-reset requests arrive after reset.

Optional Feature:
IF_PERF_CNT_EN: defined adds outputs perf_fetch_o[31:0] (count of enqueued responses) and perf_drop_o[31:0] (count of discarded responses), both reset to 0, saturating at 2^32-1. Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset release, start_i=1, zero-wait memory, ready=1 -> imem_addr_o 0,4,8,... back-to-back; first inst_valid_o two cycles after first grant with pc_o=0; then one instruction per cycle.
2. DEPTH=4, inst_ready_i=0 -> after 4 enqueues imem_req_o=0 with occupancy 4; ready=1 -> pops pc 0,4,8,12 consecutively and requests resume at 16.
3. Memory latency 3, two requests outstanding, flush_i with redirect 0x100 -> both late responses dropped, no valid output; next inst_valid_o carries pc_o=0x100.
4. Redirect 0x102 -> imem_addr_o=0x100, pc_o=0x100; flush in the same cycle as rvalid and a pending pop -> response dropped, head not popped, queue empty next cycle.
5. gnt held low 5 cycles with req high -> imem_req_o=1 and imem_addr_o stable all 5 cycles, fetch_pc advances only on grant; start_i dropped with 3 outstanding -> no new requests, all 3 instructions delivered in order.
6. IF_PERF_CNT_EN: run scenario 3 -> perf_drop_o=2, perf_fetch_o equals number of delivered instructions; asynchronous rst_i mid-run clears both counters and all outputs immediately.
